// File: rtl/booth_mult_if.sv
// booth_mult_if: request/response port of the sequential Booth multiplier
interface booth_mult_if #(parameter int WIDTH = 8);
   logic                 start_i;
   logic                 signed_i;
   logic [WIDTH-1:0]     mcand_i;
   logic [WIDTH-1:0]     mplier_i;
   logic                 busy_o;
   logic                 done_o;
   logic [2*WIDTH-1:0]   product_o;
   modport master(output start_i, signed_i, mcand_i, mplier_i, input busy_o, done_o, product_o);
   modport slave(input start_i, signed_i, mcand_i, mplier_i, output busy_o, done_o, product_o);
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 Booth multiplier, one step per clock, signed/unsigned.
// Define BOOTH_EARLY_TERM_EN to finish in one cycle once the remaining multiplier bits are uniform.
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   booth_mult_if.slave bus
);
   localparam int E  = WIDTH + 1;
   localparam int CW = $clog2(E + 1);
   typedef enum logic {IDLE, CALC} state_t;
   state_t               state_q, state_d;
   logic [E-1:0]         a_q, a_d, q_q, q_d, m_q, m_d;
   logic                 h_q, h_d, busy_q, busy_d, done_q, done_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [E-1:0]         mc_x, mp_x, sum;
   logic [2*E:0]         sh;
   logic [2*E-1:0]       fast;
   logic                 early;
   assign mc_x = {bus.signed_i & bus.mcand_i[WIDTH-1], bus.mcand_i};
   assign mp_x = {bus.signed_i & bus.mplier_i[WIDTH-1], bus.mplier_i};
   assign sum  = (q_q[0] & ~h_q) ? a_q - m_q : (~q_q[0] & h_q) ? a_q + m_q : a_q;
   assign sh   = $signed({sum, q_q, h_q}) >>> 1;
`ifdef BOOTH_EARLY_TERM_EN
   logic [E-1:0] mask;
   // Unconsumed multiplier bits sit at Q[cnt-1:0]; uniform bits equal to q0 mean only shifts remain.
   assign mask  = ~({E{1'b1}} << cnt_q);
   assign early = h_q ? ((q_q & mask) == mask) : ((q_q & mask) == '0);
   assign fast  = $signed({a_q, q_q}) >>> cnt_q;
`else
   assign early = 1'b0;
   assign fast  = {a_q, q_q};
`endif
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      h_d     = h_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
      if (state_q == IDLE) begin
         if (bus.start_i) begin
            a_d     = '0;
            q_d     = mp_x;
            h_d     = 1'b0;
            m_d     = mc_x;
            cnt_d   = CW'(E);
            busy_d  = 1'b1;
            state_d = CALC;
         end
      end else if (early) begin
         {a_d, q_d} = fast;
         cnt_d      = '0;
         prod_d     = fast[2*WIDTH-1:0];
         done_d     = 1'b1;
         busy_d     = 1'b0;
         state_d    = IDLE;
      end else begin
         {a_d, q_d, h_d} = sh;
         cnt_d           = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            prod_d  = sh[2*WIDTH:1];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         h_q     <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         h_q     <= h_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.product_o = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq (WIDTH=8), honours BOOTH_EARLY_TERM_EN.
module tb_booth_mult_seq;
   localparam int W = 8;
`ifdef BOOTH_EARLY_TERM_EN
   localparam int FULL  = 0;
   localparam int Z_LAT = 1;
`else
   localparam int FULL  = W + 1;
   localparam int Z_LAT = W + 1;
`endif
   typedef struct {logic [2*W-1:0] prod; int acc; int lat;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;
   booth_mult_if #(.WIDTH(W)) bus();
   booth_mult_seq #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] ea, eb;
      ea = {{W{s & a[W-1]}}, a};
      eb = {{W{s & b[W-1]}}, b};
      return ea * eb;
   endfunction
   always @(negedge clk) begin
      if (!rst && bus.done_o) begin
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("product", 32'(bus.product_o), 32'(e.prod));
            if (e.lat > 0) chk("latency", cyc - e.acc, e.lat);
            else chk("latency_max", 32'((cyc - e.acc) <= W + 1), 1);
         end
      end
   end
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.signed_i = s;
      bus.mcand_i  = a;
      bus.mplier_i = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      sb.push_back('{model(s, a, b), cyc, lat});
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
      sb.delete();
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout got=hang exp=finish");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.mcand_i  = '0;
      bus.mplier_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_product", 32'(bus.product_o), 0);
      rst = 1'b0;
      issue(1'b1, 8'd7, 8'hFD, FULL);
      chk("model_7x-3", 32'(model(1'b1, 8'd7, 8'hFD)), 32'hFFEB);
      drain();
      issue(1'b1, 8'h80, 8'h80, FULL);
      chk("model_min_sq", 32'(model(1'b1, 8'h80, 8'h80)), 32'h4000);
      drain();
      issue(1'b0, 8'hFF, 8'hFF, FULL);
      drain();
      issue(1'b1, 8'hFF, 8'hFF, FULL);
      drain();
      issue(1'b0, 8'd5, 8'd6, FULL);
      repeat (2) @(negedge clk);
      bus.start_i  = 1'b1;
      bus.mcand_i  = 8'd9;
      bus.mplier_i = 8'd9;
      @(negedge clk);
      bus.start_i = 1'b0;
      drain();
      chk("busy_after_done", bus.busy_o, 0);
      repeat (12) @(negedge clk);
      chk("product_held", 32'(bus.product_o), 30);
      issue(1'b1, 8'd5, 8'd7, FULL);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_done", bus.done_o, 0);
      chk("abort_product", 32'(bus.product_o), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_idle_busy", bus.busy_o, 0);
      issue(1'b1, 8'hFC, 8'd5, FULL);
      drain();
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.signed_i = 1'b1;
      bus.mcand_i  = 8'd3;
      bus.mplier_i = 8'd4;
      @(negedge clk);
      sb.push_back('{16'd12, cyc, FULL});
      bus.mcand_i  = 8'd10;
      bus.mplier_i = 8'hFE;
      n = 0;
      while (!bus.done_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", bus.done_o, 1);
      chk("b2b_busy_in_done", bus.busy_o, 0);
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("b2b_accepted", bus.busy_o, 1);
      sb.push_back('{16'hFFEC, cyc, FULL});
      drain();
      issue(1'b1, 8'd100, 8'd0, Z_LAT);
      drain();
      issue(1'b1, 8'd100, 8'hFF, FULL);
      chk("model_100x-1", 32'(model(1'b1, 8'd100, 8'hFF)), 32'hFF9C);
      drain();
      for (int i = 0; i < 24; i++) begin
         issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), FULL);
         drain();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
